// File: rtl/multdiv_tracker.sv
// Tracks in-flight multi-cycle MUL/DIV ops through a DEPTH-slot compacting pipe.
// Optional feature macro: MULTDIV_EXC_TRACK_EN (per-slot divide-by-zero exception tracking).
module multdiv_tracker #(
  parameter int DEPTH = 17,
  parameter int REG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic             issue_is_div,
  input  logic [REG_W-1:0] issue_rd,
`ifdef MULTDIV_EXC_TRACK_EN
  input  logic             issue_divisor_zero,
`endif
  output logic             issue_ready,
  input  logic             retire,
  input  logic [REG_W-1:0] dx_rs,
  input  logic [REG_W-1:0] dx_rt,
  input  logic [REG_W-1:0] dx_rd,
  input  logic [2:0]       dx_reads,
  output logic [DEPTH-1:0] busy_stage,
  output logic [DEPTH-1:0] bp_req,
  output logic             exc_piped,
  output logic [REG_W-1:0] result_rd,
  output logic             result_is_div,
  output logic             result_exc
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] div_q, div_d;
  logic [REG_W-1:0] rd_q [DEPTH];
  logic [REG_W-1:0] rd_d [DEPTH];
`ifdef MULTDIV_EXC_TRACK_EN
  logic [DEPTH-1:0] exc_q, exc_d;
`endif
  logic [DEPTH-1:0] adv;
  logic             accept;

  // Advance chain runs from the writeback slot downwards so bubbles close up.
  always_comb begin : adv_chain
    logic carry;
    logic a;
    adv   = '0;
    carry = retire;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      a      = valid_q[k] & carry;
      adv[k] = a;
      carry  = ~valid_q[k] | a;
    end
  end

  assign issue_ready = ~valid_q[0] | adv[0];
  assign accept      = issue_valid & issue_ready;

  always_comb begin
    valid_d = valid_q;
    div_d   = div_q;
    rd_d    = rd_q;
`ifdef MULTDIV_EXC_TRACK_EN
    exc_d   = exc_q;
`endif
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (adv[k-1]) begin
        valid_d[k] = 1'b1;
        div_d[k]   = div_q[k-1];
        rd_d[k]    = rd_q[k-1];
`ifdef MULTDIV_EXC_TRACK_EN
        exc_d[k]   = exc_q[k-1];
`endif
      end else if (adv[k]) begin
        valid_d[k] = 1'b0;
      end
    end
    if (accept) begin
      valid_d[0] = 1'b1;
      div_d[0]   = issue_is_div;
      rd_d[0]    = issue_rd;
`ifdef MULTDIV_EXC_TRACK_EN
      exc_d[0]   = issue_is_div & issue_divisor_zero;
`endif
    end else if (adv[0]) begin
      valid_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      div_q   <= '0;
      for (int k = 0; k < DEPTH; k++) rd_q[k] <= '0;
`ifdef MULTDIV_EXC_TRACK_EN
      exc_q   <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      div_q   <= div_d;
      rd_q    <= rd_d;
`ifdef MULTDIV_EXC_TRACK_EN
      exc_q   <= exc_d;
`endif
    end
  end

  // RAW hit: dx_reads = {reads_rd, reads_rs, reads_rt}; $r0 never forwards.
  always_comb begin
    bp_req = '0;
    for (int k = 0; k < DEPTH; k++) begin
      bp_req[k] = valid_q[k] & (rd_q[k] != '0) &
                  ((dx_reads[1] & (rd_q[k] == dx_rs)) |
                   (dx_reads[0] & (rd_q[k] == dx_rt)) |
                   (dx_reads[2] & (rd_q[k] == dx_rd)));
    end
  end

  assign busy_stage    = valid_q;
  assign result_rd     = rd_q[DEPTH-1];
  assign result_is_div = div_q[DEPTH-1];
`ifdef MULTDIV_EXC_TRACK_EN
  assign exc_piped     = |(valid_q & div_q);
  assign result_exc    = exc_q[DEPTH-1];
`else
  assign exc_piped     = |valid_q;
  assign result_exc    = 1'b0;
`endif

endmodule
